updown_code_counter: RTL and testbench



---
 rtl/updown_code_counter.sv | 89 ++++++++
 tb/tb_updown_code_counter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/updown_code_counter.sv
`default_nettype none
// ============================================================================
// Module  : updown_code_counter
// Brief   : Up/down modulo counter with binary, Gray and one-hot outputs.
// Revision: 1.0
// ============================================================================
module updown_code_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               dir_i,
  input  logic               sat_i,
  input  logic               load_i,
  input  logic [WIDTH-1:0]   load_val_i,
  output logic [WIDTH-1:0]   bin_out_o,
  output logic [WIDTH-1:0]   gray_out_o,
  output logic [MODULUS-1:0] onehot_out_o,
  output logic               tc_o,
  output logic               wrap_o
);

  localparam logic [WIDTH-1:0] C_MAX_CNT = WIDTH'(MODULUS - 1);

  if (MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_modulus
    $error("updown_code_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] load_clamped;

  // A full-range modulus cannot receive an out-of-range load value.
  if (MODULUS == 2**WIDTH) begin : g_clamp_none
    assign load_clamped = load_val_i;
  end else begin : g_clamp
    assign load_clamped = (load_val_i > C_MAX_CNT) ? C_MAX_CNT : load_val_i;
  end

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load_i) begin
      cnt_d = load_clamped;
    end else if (en_i) begin
      if (dir_i) begin
        if (cnt_q != C_MAX_CNT) begin
          cnt_d = cnt_q + WIDTH'(1);
        end else if (!sat_i) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end
      end else begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WIDTH'(1);
        end else if (!sat_i) begin
          cnt_d  = C_MAX_CNT;
          wrap_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  always_comb begin
    onehot_out_o = '0;
    for (int i = 0; i < MODULUS; i++) begin
      onehot_out_o[i] = (cnt_q == WIDTH'(i));
    end
  end

  assign bin_out_o  = cnt_q;
  assign gray_out_o = cnt_q ^ (cnt_q >> 1);
  assign tc_o       = (dir_i && (cnt_q == C_MAX_CNT)) || (!dir_i && (cnt_q == '0));
  assign wrap_o     = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_updown_code_counter.sv
`default_nettype none
// Testbench for updown_code_counter: table vectors against a full-range
// (MODULUS=8) and a partial-range (MODULUS=6) instance sharing stimulus.
module tb_updown_code_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, dir = 1'b0, sat = 1'b0, load = 1'b0;
  logic [2:0] load_val = '0;

  logic [2:0] bin8, gray8, bin6, gray6;
  logic [7:0] oh8;
  logic [5:0] oh6;
  logic       tc8, wrap8, tc6, wrap6;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  updown_code_counter #(.WIDTH(3), .MODULUS(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .dir_i(dir), .sat_i(sat),
    .load_i(load), .load_val_i(load_val), .bin_out_o(bin8), .gray_out_o(gray8),
    .onehot_out_o(oh8), .tc_o(tc8), .wrap_o(wrap8)
  );

  updown_code_counter #(.WIDTH(3), .MODULUS(6)) dut6 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .dir_i(dir), .sat_i(sat),
    .load_i(load), .load_val_i(load_val), .bin_out_o(bin6), .gray_out_o(gray6),
    .onehot_out_o(oh6), .tc_o(tc6), .wrap_o(wrap6)
  );

  typedef struct {
    logic       rst_before;
    logic       ld;
    logic [2:0] lv;
    logic       e, d, s;
    logic [2:0] bin;
    logic       wrp;
    logic       tc;
  } vec_t;

  typedef struct {
    logic [2:0] bin8;
    logic       wrap8, tc8;
    logic [2:0] bin6;
    logic       wrap6, tc6;
  } exp_t;

  localparam int NV = 29;
  vec_t vecs [NV];
  exp_t sb [$];

  // Independent reference for the MODULUS=6 instance.
  logic [2:0] m6_cnt;
  logic       m6_wrap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m6_step(input logic ld, input logic [2:0] lv, input logic e,
                         input logic d, input logic s);
    m6_wrap = 1'b0;
    if (ld) begin
      m6_cnt = (lv > 3'd5) ? 3'd5 : lv;
    end else if (e && d) begin
      if (m6_cnt < 3'd5) m6_cnt = m6_cnt + 3'd1;
      else if (!s) begin m6_cnt = 3'd0; m6_wrap = 1'b1; end
    end else if (e && !d) begin
      if (m6_cnt > 3'd0) m6_cnt = m6_cnt - 3'd1;
      else if (!s) begin m6_cnt = 3'd5; m6_wrap = 1'b1; end
    end
  endtask

  task automatic check_outputs(input exp_t e);
    logic [2:0] b8, b6;
    b8 = e.bin8;
    b6 = e.bin6;
    check("bin8",    32'(bin8),  32'(b8));
    check("gray8",   32'(gray8), 32'(b8 ^ (b8 >> 1)));
    check("onehot8", 32'(oh8),   32'(8'd1 << b8));
    check("wrap8",   32'(wrap8), 32'(e.wrap8));
    check("tc8",     32'(tc8),   32'(e.tc8));
    check("bin6",    32'(bin6),  32'(b6));
    check("gray6",   32'(gray6), 32'(b6 ^ (b6 >> 1)));
    check("onehot6", 32'(oh6),   32'(6'd1 << b6));
    check("wrap6",   32'(wrap6), 32'(e.wrap6));
    check("tc6",     32'(tc6),   32'(e.tc6));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    exp_t e;
    // rst_before, load, lv, en, dir, sat, exp bin, exp wrap, exp tc  (MODULUS=8)
    vecs[0]  = '{0,0,0, 1,1,0, 3'd1,0,0};
    vecs[1]  = '{0,0,0, 1,1,0, 3'd2,0,0};
    vecs[2]  = '{0,0,0, 1,1,0, 3'd3,0,0};
    vecs[3]  = '{0,0,0, 1,1,0, 3'd4,0,0};
    vecs[4]  = '{0,0,0, 1,1,0, 3'd5,0,0};
    vecs[5]  = '{0,0,0, 1,1,0, 3'd6,0,0};
    vecs[6]  = '{0,0,0, 1,1,0, 3'd7,0,1};
    vecs[7]  = '{0,0,0, 1,1,0, 3'd0,1,0};
    vecs[8]  = '{0,0,0, 1,1,0, 3'd1,0,0};
    vecs[9]  = '{1,0,0, 1,0,0, 3'd7,1,0};
    vecs[10] = '{0,0,0, 1,0,0, 3'd6,0,0};
    vecs[11] = '{0,0,0, 1,0,0, 3'd5,0,0};
    vecs[12] = '{0,1,6, 0,1,1, 3'd6,0,0};
    vecs[13] = '{0,0,0, 1,1,1, 3'd7,0,1};
    vecs[14] = '{0,0,0, 1,1,1, 3'd7,0,1};
    vecs[15] = '{0,0,0, 1,1,1, 3'd7,0,1};
    vecs[16] = '{0,1,7, 0,1,0, 3'd7,0,1};
    vecs[17] = '{0,0,0, 1,1,0, 3'd0,1,0};
    vecs[18] = '{0,1,3, 1,1,0, 3'd3,0,0};
    vecs[19] = '{0,1,1, 1,1,0, 3'd1,0,0};
    vecs[20] = '{0,0,0, 1,0,0, 3'd0,0,1};
    vecs[21] = '{0,0,0, 1,1,0, 3'd1,0,0};
    vecs[22] = '{0,0,0, 0,0,0, 3'd1,0,0};
    vecs[23] = '{0,0,0, 1,0,1, 3'd0,0,1};
    vecs[24] = '{0,0,0, 1,0,1, 3'd0,0,1};
    vecs[25] = '{0,0,0, 1,0,0, 3'd7,1,0};
    vecs[26] = '{0,0,0, 1,0,0, 3'd6,0,0};
    vecs[27] = '{0,0,0, 1,1,0, 3'd7,0,1};
    vecs[28] = '{0,0,0, 1,1,0, 3'd0,1,0};

    m6_cnt  = 3'd0;
    m6_wrap = 1'b0;

    // Reset state, dir=0 so tc reflects cnt==0.
    repeat (2) @(posedge clk);
    #1;
    e = '{3'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1};
    check_outputs(e);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if (vecs[i].rst_before) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        m6_cnt  = 3'd0;
        m6_wrap = 1'b0;
      end
      load = vecs[i].ld; load_val = vecs[i].lv;
      en = vecs[i].e; dir = vecs[i].d; sat = vecs[i].s;
      if (vecs[i].rst_before) begin
        #1;
        check("post_reset_bin8", 32'(bin8), 32'd0);
        check("post_reset_tc8",  32'(tc8),  32'(!vecs[i].d));
      end
      m6_step(vecs[i].ld, vecs[i].lv, vecs[i].e, vecs[i].d, vecs[i].s);
      sb.push_back('{vecs[i].bin, vecs[i].wrp, vecs[i].tc, m6_cnt, m6_wrap,
                     (vecs[i].d && m6_cnt == 3'd5) || (!vecs[i].d && m6_cnt == 3'd0)});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard: got empty queue expected entry for vector %0d", i);
      end else begin
        e = sb.pop_front();
        check_outputs(e);
      end
    end

    // Asynchronous reset mid-count with cnt=5.
    @(negedge clk);
    load = 1'b1; load_val = 3'd5; en = 1'b0; dir = 1'b1; sat = 1'b0;
    @(posedge clk);
    #1;
    check("preload_bin8", 32'(bin8), 32'd5);
    check("preload_bin6", 32'(bin6), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    e = '{3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    check_outputs(e);
    load = 1'b0; en = 1'b1;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("resume_bin8", 32'(bin8), 32'd1);
    check("resume_bin6", 32'(bin6), 32'd1);
    check("resume_wrap8", 32'(wrap8), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
